// File: rtl/dsm_cic_decimator_pkg.sv
// Shared constants for the delta-sigma link and the CIC decimator.
// DSM_top uses the same sample width and full-scale value.
package dsm_cic_decimator_pkg;

  localparam int DSM_SAMPLE_W         = 20;
  localparam int DSM_DEC_LOG2_DEFAULT = 6;
  localparam int DSM_CIC_ORDER        = 3;
  localparam int DSM_FS               = 262144;

  // Bit growth of an order-N CIC at ratio 2^dec_log2, plus sign and +/-1 input.
  function automatic int cic_acc_w(input int order, input int dec_log2);
    return 2 + order * dec_log2;
  endfunction

endpackage

// File: rtl/dsm_cic_integrator.sv
// One CIC integrator stage: modulo-2^W accumulator that advances only when en.
module dsm_cic_integrator #(
  parameter int W = 20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);

  // Wrap-around is relied on by the combs; never saturate here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)   acc <= '0;
    else if (en) acc <= acc + din;
  end

endmodule

// File: rtl/dsm_cic_decimator.sv
// Sinc^3 decimator: turns the 1-bit pwm bitstream back into signed OUT_W samples,
// one output per 2^DEC_LOG2 enabled bits, full scale +/-R^3.
module dsm_cic_decimator
  import dsm_cic_decimator_pkg::*;
#(
  parameter int DEC_LOG2 = DSM_DEC_LOG2_DEFAULT,
  parameter int ORDER    = DSM_CIC_ORDER,
  parameter int OUT_W    = DSM_SAMPLE_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             pwm,
  output logic [OUT_W-1:0] vout,
  output logic             vout_valid
);

  localparam int ACC_W  = cic_acc_w(ORDER, DEC_LOG2);
  localparam int WARM_W = $clog2(ORDER + 1);

  logic [ACC_W-1:0]              integ [ORDER+1];
  logic [ORDER-1:0][ACC_W-1:0]   dly;
  logic [ORDER-1:0][ACC_W-1:0]   comb;
  logic [ACC_W-1:0]              comb_run;
  logic [DEC_LOG2-1:0]           cnt;
  logic [WARM_W-1:0]             warm;
  logic                          tick;
  logic                          warm_done;
  logic [OUT_W-1:0]              vout_nxt;

  // pwm=1 -> +1, pwm=0 -> -1 (all ones)
  assign integ[0] = pwm ? ACC_W'(1) : '1;

  for (genvar k = 0; k < ORDER; k++) begin : g_int
    dsm_cic_integrator #(.W(ACC_W)) u_int (
      .clock (clock),
      .reset (reset),
      .en    (bit_en),
      .din   (integ[k]),
      .acc   (integ[k+1])
    );
  end

  assign tick      = bit_en & (&cnt);
  assign warm_done = (warm == WARM_W'(ORDER));

  always_comb begin
    comb     = '0;
    comb_run = integ[ORDER];
    for (int k = 0; k < ORDER; k++) begin
      comb_run = comb_run - dly[k];
      comb[k]  = comb_run;
    end
  end

  if (ACC_W >= OUT_W) begin : g_out_shr
    assign vout_nxt = comb[ORDER-1][ACC_W-1 -: OUT_W];
  end else begin : g_out_sext
    assign vout_nxt = {{(OUT_W-ACC_W){comb[ORDER-1][ACC_W-1]}}, comb[ORDER-1]};
  end

  // The first ORDER ticks only prime the comb delays; their outputs are transient.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      warm       <= '0;
      dly        <= '0;
      vout       <= '0;
      vout_valid <= 1'b0;
    end else begin
      vout_valid <= 1'b0;
      if (bit_en) cnt <= cnt + DEC_LOG2'(1);
      if (tick) begin
        dly[0] <= integ[ORDER];
        for (int k = 1; k < ORDER; k++) dly[k] <= comb[k-1];
        if (warm_done) begin
          vout       <= vout_nxt;
          vout_valid <= 1'b1;
        end else begin
          warm <= warm + WARM_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Directed bench for dsm_cic_decimator: steady-state levels, strobe timing,
// gapped enables, integrator wrap and asynchronous reset.
module tb_dsm_cic_decimator;
  import dsm_cic_decimator_pkg::*;

  logic        clock;
  logic        reset;
  logic        bit_en;
  logic        pwm;
  logic [19:0] vout;
  logic        vout_valid;

  int checks;
  int errors;
  int bits;   // enabled bits consumed since the last reset

  logic [19:0] pos_fs;
  logic [19:0] neg_fs;
  logic [19:0] half_fs;

  dsm_cic_decimator dut (
    .clock      (clock),
    .reset      (reset),
    .bit_en     (bit_en),
    .pwm        (pwm),
    .vout       (vout),
    .vout_valid (vout_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic apply_reset();
    reset  = 1'b1;
    bit_en = 1'b0;
    pwm    = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    bits  = 0;
  endtask

  // mode: 0 const +1, 1 const -1, 2 alternating 1,0, 3 pattern 1,1,1,0.
  // Strobe timing is checked every cycle; vout only from bit chk_from on.
  task automatic drive(input int nbits, input int mode, input bit gaps,
                       input int chk_from, input logic [19:0] expv);
    for (int i = 0; i < nbits; i++) begin
      logic p;
      logic exp_vld;
      case (mode)
        0:       p = 1'b1;
        1:       p = 1'b0;
        2:       p = (bits % 2 == 0);
        default: p = (bits % 4 != 3);
      endcase
      bit_en = 1'b1;
      pwm    = p;
      @(posedge clock);
      bits++;
      @(negedge clock);
      exp_vld = (bits % 64 == 0) && (bits >= 256);
      checks++;
      if (vout_valid !== exp_vld) begin
        errors++;
        $display("FAIL strobe bit=%0d: vout_valid=%b expected %b", bits, vout_valid, exp_vld);
      end
      if (exp_vld && bits >= chk_from) begin
        checks++;
        if (vout !== expv) begin
          errors++;
          $display("FAIL value bit=%0d mode=%0d: vout=%h expected %h", bits, mode, vout, expv);
        end
      end
      if (gaps) begin
        bit_en = 1'b0;
        pwm    = 1'bx;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (vout_valid !== 1'b0 || $isunknown(vout)) begin
          errors++;
          $display("FAIL gap bit=%0d: vout_valid=%b vout=%h expected valid 0, vout known",
                   bits, vout_valid, vout);
        end
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (vout !== 20'h0 || vout_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset: vout=%h valid=%b expected 00000/0", vout, vout_valid);
    end
    // Idle with bit_en low: nothing may happen.
    repeat (300) @(negedge clock);
    checks++;
    if (vout !== 20'h0 || vout_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle: vout=%h valid=%b expected 00000/0", vout, vout_valid);
    end
  endtask

  task automatic test_const_pos();
    apply_reset();
    drive(256 + 64*3, 0, 1'b0, 0, pos_fs);
  endtask

  task automatic test_const_neg();
    apply_reset();
    drive(256 + 64*3, 1, 1'b0, 0, neg_fs);
  endtask

  task automatic test_alternating();
    apply_reset();
    drive(256 + 64*3, 2, 1'b0, 0, 20'h0);
  endtask

  task automatic test_gapped();
    apply_reset();
    drive(256 + 64*2, 0, 1'b1, 0, pos_fs);
  endtask

  // A long +1 run wraps I2/I3 many times; the combs must still be exact.
  task automatic test_wrap();
    apply_reset();
    drive(4096, 0, 1'b0, 0, pos_fs);
    drive(512, 2, 1'b0, 4096 + 256, 20'h0);
  endtask

  // DC of 0.5: three +1 and one -1 per four bits.
  task automatic test_half_scale();
    apply_reset();
    drive(256 + 64*3, 3, 1'b0, 0, half_fs);
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(320, 0, 1'b0, 0, pos_fs);
    drive(37, 0, 1'b0, 0, pos_fs);
    checks++;
    if (vout !== pos_fs) begin
      errors++;
      $display("FAIL pre-reset hold: vout=%h expected %h", vout, pos_fs);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (vout !== 20'h0 || vout_valid !== 1'b0) begin
      errors++;
      $display("FAIL async reset: vout=%h valid=%b expected 00000/0", vout, vout_valid);
    end
    @(negedge clock);
    reset = 1'b0;
    bits  = 0;
    drive(256 + 64, 0, 1'b0, 0, pos_fs);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    bits    = 0;
    reset   = 1'b1;
    bit_en  = 1'b0;
    pwm     = 1'b0;
    pos_fs  = 20'(DSM_FS);
    neg_fs  = 20'(-DSM_FS);
    half_fs = 20'(DSM_FS / 2);

    test_reset();
    test_const_pos();
    test_const_neg();
    test_alternating();
    test_gapped();
    test_wrap();
    test_half_scale();
    test_async_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
